fifo_uart_tx: RTL



---
 rtl/fifo_uart_pkg.sv | 31 +++
 rtl/uart_baud_cnt.sv | 50 +++++
 rtl/fifo_uart_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and constants for the FIFO-fed UART transmitter.
//   uart_state_e : 3-bit FSM state encoding (IDLE, FETCH, START, DATA, PARITY, STOP)
//   DATA_BITS    : payload width, tied to the 8-bit FIFO word
//   IDLE_LEVEL   : line level when idle / during the stop bit
//   START_LEVEL  : line level during the start bit
//   even_parity  : XOR reduction of a data byte (used only when
//                  FIFO_UART_TX_PARITY_EN is defined)
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_e;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps to 0 by itself after
// the last count; clear_i forces it to 0 (used while no bit is being sent).
// Ports:
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clear_i   : synchronous clear, holds the counter at 0
//   cnt_o     : current count
//   bit_end_o : high on the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int  CLKS_PER_BIT = 16,
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             bit_end_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear or wrap at end of bit, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign bit_end_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains bytes from a 4-deep 8-bit FIFO (registered read, data valid the cycle
// after rd_en) and sends each one as a UART frame: start, 8 data bits LSB
// first, optional even parity bit, one stop bit.
// Build option: define FIFO_UART_TX_PARITY_EN to insert the parity bit.
// Ports:
//   clk        : clock, posedge
//   reset      : asynchronous active-low reset
//   tx_enable  : allows a new frame to start (sampled only in IDLE)
//   fifo_empty : FIFO empty flag
//   fifo_dout  : FIFO read data
//   fifo_rd_en : one-cycle pop request, only ever raised in IDLE
//   tx         : serial line, idle high, registered
//   busy       : high from the pop cycle until the end of the stop bit
//   frame_done : one-cycle pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 pop_s;
    logic                 cnt_clear_s;
    logic                 bit_end_s;
    logic [CNT_W-1:0]     cnt_s;

    // The pop must be seen by the FIFO in the IDLE cycle itself so the byte is
    // on fifo_dout during FETCH; gating with reset keeps it low while in reset.
    assign pop_s       = reset && (state_q == IDLE) && tx_enable && !fifo_empty;
    assign cnt_clear_s = (state_q == IDLE) || (state_q == FETCH);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (cnt_clear_s),
        .cnt_o     (cnt_s),
        .bit_end_o (bit_end_s)
    );

    // Next-state, shift register and bit index.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                shift_d = fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = even_parity(fifo_dout);
`endif
                state_d = START;
            end
            START: begin
                if (bit_end_s) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        bit_idx_d = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level and done pulse are derived from the next state so the
    // registered outputs line up with the state register.
    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
        // One cycle before the final stop cycle, so the pulse lands on it.
        if ((state_q == STOP) && (cnt_s == CNT_W'(CLKS_PER_BIT - 2)) && !bit_end_s) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= 3'd0;
            tx_q      <= IDLE_LEVEL;
            done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign fifo_rd_en = pop_s;
    assign busy       = (state_q != IDLE) || pop_s;
    assign tx         = tx_q;
    assign frame_done = done_q;

endmodule
